// File: rtl/mcycle_unit_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op encodings,
// state encodings and the default operand width.
package mcycle_unit_pkg;
   localparam int DEFAULT_WIDTH = 32;

   localparam logic MCYCLE_MUL = 1'b0;
   localparam logic MCYCLE_DIV = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;
endpackage

// File: rtl/mcycle_unit_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and emit the quotient bit.
module mcycle_unit_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_nx,
   output logic             qbit
);
   logic [WIDTH:0] shifted;

   // Compare at WIDTH+1 bits so divisors with the top bit set still work;
   // when the subtract happens the difference always fits in WIDTH bits.
   assign shifted = {rem, msb};
   assign qbit    = (shifted >= {1'b0, divisor});
   assign rem_nx  = qbit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
endmodule

// File: rtl/mcycle_unit.sv
// Iterative unsigned multiply / restoring divide with pipeline stall (Busy).
// The divide datapath is present only when MCYCLE_DIV_EN is defined.
module mcycle_unit
   import mcycle_unit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Start,
   input  logic             MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   opa;      // multiplicand, or dividend shifting into quotient
   logic [2*WIDTH-1:0] acc;      // {partial product, remaining multiplier bits}
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_nx;

   assign Busy = (state == S_IDLE && Start) || state == S_MUL || state == S_DIV;

   assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : '0)};
   assign acc_nx = {sum, acc[WIDTH-1:1]};

`ifdef MCYCLE_DIV_EN
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] rem_nx;
   logic             qbit;

   mcycle_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem     (rem),
      .msb     (opa[WIDTH-1]),
      .divisor (opb),
      .rem_nx  (rem_nx),
      .qbit    (qbit)
   );
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state   <= S_IDLE;
         cnt     <= '0;
         opa     <= '0;
         acc     <= '0;
         Result1 <= '0;
         Result2 <= '0;
`ifdef MCYCLE_DIV_EN
         opb     <= '0;
         rem     <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: if (Start) begin
               cnt <= '0;
               opa <= Operand1;
               acc <= {{WIDTH{1'b0}}, Operand2};
`ifdef MCYCLE_DIV_EN
               opb <= Operand2;
               rem <= '0;
`endif
               if (MCycleOp == MCYCLE_MUL) begin
                  state <= S_MUL;
               end else begin
`ifdef MCYCLE_DIV_EN
                  state   <= S_DIV;
`else
                  Result1 <= '0;
                  Result2 <= '0;
                  state   <= S_DONE;
`endif
               end
            end
            S_MUL: begin
               acc <= acc_nx;
               if (cnt == LAST) begin
                  Result1 <= acc_nx[WIDTH-1:0];
                  Result2 <= acc_nx[2*WIDTH-1:WIDTH];
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`ifdef MCYCLE_DIV_EN
            S_DIV: begin
               rem <= rem_nx;
               opa <= {opa[WIDTH-2:0], qbit};
               if (cnt == LAST) begin
                  Result1 <= {opa[WIDTH-2:0], qbit};
                  Result2 <= rem_nx;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`endif
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
